// File: rtl/tx_sym_scheduler.sv
// tx_sym_scheduler
// Turns a queue of 4-ASK symbol indices into a zero-stuffed sample stream for a
// 21-tap pulse-shaping filter. One symbol is emitted every OSR sample strobes,
// with OSR-1 zeros stuffed between symbols. A stop request lets the current
// symbol finish, then FLUSH_LEN zero samples drain the filter.
//
// Parameters:
//   OSR        samples per symbol (2..16)
//   FLUSH_LEN  zero samples emitted in FLUSH (entry strobe included)
//   FIFO_DEPTH symbol FIFO entries, power of two, at least 2
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start, stop       one-cycle request pulses
//   sym_in/sym_valid  symbol push side; sym_ready = FIFO not full
//   samp_en           sample-rate strobe
//   x_out/x_valid     registered signed 1s17 sample and its strobe
//   busy              high in RUN or FLUSH
//   underrun_cnt      saturating count of symbol slots that found the FIFO empty
//
// Optional feature (macro TX_SCHED_IMPULSE_EN): adds input impulse_req. A request
// in IDLE emits a single full-scale sample on the next strobe, then a flush.
module tx_sym_scheduler #(
   parameter int OSR        = 4,
   parameter int FLUSH_LEN  = 21,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic [1:0]  sym_in,
   input  logic        sym_valid,
   output logic        sym_ready,
   input  logic        samp_en,
   output logic [17:0] x_out,
   output logic        x_valid,
   output logic        busy,
   output logic [7:0]  underrun_cnt
`ifdef TX_SCHED_IMPULSE_EN
   ,
   input  logic        impulse_req
`endif
);

   localparam int PW = $clog2(OSR);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = $clog2(FLUSH_LEN + 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic            stop_q, stop_d;
   logic [FW-1:0]   flush_q, flush_d;
   logic [17:0]     x_out_q, x_out_d;
   logic            x_valid_q, x_valid_d;
   logic [7:0]      underrun_q, underrun_d;
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic [1:0]      fifo_mem_q [FIFO_DEPTH];
   logic [1:0]      head_sym;
   logic [17:0]     head_level;
   logic            fifo_full, fifo_empty, push, pop;
`ifdef TX_SCHED_IMPULSE_EN
   logic            impulse_q, impulse_d;
`endif

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign sym_ready  = !fifo_full;
   assign push       = sym_valid && !fifo_full;
   assign head_sym   = fifo_mem_q[rd_ptr_q[AW-1:0]];

   // 4-ASK level table in 1s17: -1, -1/3, +1/3, +1 (full scale).
   always_comb begin
      head_level = 18'h00000;
      case (head_sym)
         2'd0: head_level = 18'h20000;
         2'd1: head_level = 18'h35556;
         2'd2: head_level = 18'h0AAAA;
         2'd3: head_level = 18'h1FFFF;
         default: head_level = 18'h00000;
      endcase
   end

   // Next-state logic. A phase-0 slot reads fifo_empty from the registered
   // pointers, so a push on the same edge cannot fill that slot.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      stop_d     = stop_q;
      flush_d    = flush_q;
      x_out_d    = x_out_q;
      x_valid_d  = 1'b0;
      underrun_d = underrun_q;
      pop        = 1'b0;
`ifdef TX_SCHED_IMPULSE_EN
      impulse_d  = impulse_q;
`endif
      case (state_q)
         IDLE: begin
            x_out_d = 18'h00000;
            if (start) begin
               state_d = RUN;
               phase_d = '0;
               stop_d  = 1'b0;
`ifdef TX_SCHED_IMPULSE_EN
               impulse_d = 1'b0;
            end else if (impulse_q && samp_en) begin
               x_out_d   = 18'h1FFFF;
               x_valid_d = 1'b1;
               impulse_d = 1'b0;
               state_d   = FLUSH;
               flush_d   = '0;
            end else if (impulse_req) begin
               impulse_d = 1'b1;
`endif
            end
         end
         RUN: begin
            if (stop) begin
               stop_d = 1'b1;
            end
            if (samp_en) begin
               x_valid_d = 1'b1;
               x_out_d   = 18'h00000;
               phase_d   = (phase_q == PW'(OSR - 1)) ? '0 : phase_q + 1'b1;
               if (phase_q == '0) begin
                  if (stop_q) begin
                     stop_d = 1'b0;
                     if (FLUSH_LEN > 1) begin
                        state_d = FLUSH;
                        flush_d = FW'(1);
                     end else begin
                        state_d = IDLE;
                     end
                  end else if (!fifo_empty) begin
                     pop     = 1'b1;
                     x_out_d = head_level;
                  end else if (underrun_q != 8'hFF) begin
                     underrun_d = underrun_q + 8'd1;
                  end
               end
            end
         end
         FLUSH: begin
            if (samp_en) begin
               x_valid_d = 1'b1;
               x_out_d   = 18'h00000;
               if (flush_q == FW'(FLUSH_LEN - 1)) begin
                  state_d = IDLE;
               end else begin
                  flush_d = flush_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
   end

   // State and pointer registers; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         stop_q     <= 1'b0;
         flush_q    <= '0;
         x_out_q    <= 18'h00000;
         x_valid_q  <= 1'b0;
         underrun_q <= 8'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
`ifdef TX_SCHED_IMPULSE_EN
         impulse_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         stop_q     <= stop_d;
         flush_q    <= flush_d;
         x_out_q    <= x_out_d;
         x_valid_q  <= x_valid_d;
         underrun_q <= underrun_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
`ifdef TX_SCHED_IMPULSE_EN
         impulse_q  <= impulse_d;
`endif
      end
   end

   // Storage needs no reset: emptiness is decided by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q[AW-1:0]] <= sym_in;
      end
   end

   assign x_out        = x_out_q;
   assign x_valid      = x_valid_q;
   assign busy         = (state_q != IDLE);
   assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_tx_sym_scheduler.sv
// Directed testbench for tx_sym_scheduler (OSR 4, FLUSH_LEN 21, FIFO_DEPTH 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so every check sees the result of the preceding edge.
module tb_tx_sym_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  sym_in = 2'd0;
   logic        sym_valid = 1'b0;
   logic        sym_ready;
   logic        samp_en = 1'b0;
   logic [17:0] x_out;
   logic        x_valid;
   logic        busy;
   logic [7:0]  underrun_cnt;
`ifdef TX_SCHED_IMPULSE_EN
   logic        impulse_req = 1'b0;
`endif

   int total = 0;
   int bad = 0;

   tx_sym_scheduler #(.OSR(4), .FLUSH_LEN(21), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .sym_in       (sym_in),
      .sym_valid    (sym_valid),
      .sym_ready    (sym_ready),
      .samp_en      (samp_en),
      .x_out        (x_out),
      .x_valid      (x_valid),
      .busy         (busy),
      .underrun_cnt (underrun_cnt)
`ifdef TX_SCHED_IMPULSE_EN
      ,
      .impulse_req  (impulse_req)
`endif
   );

   always #5 clk = ~clk;

   // Advance n rising edges and settle just after the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic pushSym(input logic [1:0] s);
      sym_in    = s;
      sym_valid = 1'b1;
      tick(1);
      sym_valid = 1'b0;
   endtask

   // One sample strobe, then the sample and its valid are checked one clock
   // later, followed by a quiet cycle where valid must drop; 4 clocks total.
   task automatic applyStimulus(input string tag, input int expected);
      samp_en = 1'b1;
      tick(1);
      samp_en = 1'b0;
      checkOutput({tag, " x_out"}, $signed(x_out), expected);
      checkOutput({tag, " x_valid"}, x_valid, 1);
      tick(1);
      checkOutput({tag, " x_valid low"}, x_valid, 0);
      tick(2);
   endtask

   initial begin : main
      int exp_seq [15];
      bit nonzero_seen;
      exp_seq = '{0, 0, 0, -131072, 0, 0, 0, -43690, 0, 0, 0, 43690, 0, 0, 0};

      // Reset values
      tick(1);
      reset = 1'b0;
      checkOutput("rst x_out", $signed(x_out), 0);
      checkOutput("rst x_valid", x_valid, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst underrun", underrun_cnt, 0);
      checkOutput("rst sym_ready", sym_ready, 1);

      // Fill FIFO with 3,0,1,2; a fifth symbol is held off while full
      pushSym(2'd3);
      pushSym(2'd0);
      pushSym(2'd1);
      pushSym(2'd2);
      checkOutput("full sym_ready", sym_ready, 0);
      sym_in    = 2'd3;
      sym_valid = 1'b1;
      tick(1);
      checkOutput("held fifth sym_ready", sym_ready, 0);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      checkOutput("start busy", busy, 1);

      // First strobe pops symbol 3; the held fifth symbol goes in next edge
      samp_en = 1'b1;
      tick(1);
      samp_en = 1'b0;
      checkOutput("first x_out", $signed(x_out), 131071);
      checkOutput("first x_valid", x_valid, 1);
      checkOutput("pop sym_ready", sym_ready, 1);
      tick(1);
      sym_valid = 1'b0;
      checkOutput("first x_valid low", x_valid, 0);
      checkOutput("fifth accepted", sym_ready, 0);
      tick(2);

      // Remaining 15 samples of the 3,0,1,2 stream
      for (int i = 0; i < 15; i++) begin
         applyStimulus($sformatf("seq%0d", i + 1), exp_seq[i]);
      end
      checkOutput("seq underrun", underrun_cnt, 0);

      // FIFO now holds 3; add 0. Stop lands at phase 2.
      pushSym(2'd0);
      applyStimulus("stop p0", 131071);
      applyStimulus("stop p1", 0);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      applyStimulus("stop p2", 0);
      applyStimulus("stop p3", 0);
      checkOutput("pre-flush busy", busy, 1);
      applyStimulus("flush entry", 0);
      checkOutput("flush entry busy", busy, 1);
      for (int i = 1; i < 20; i++) begin
         applyStimulus($sformatf("flush%0d", i), 0);
      end
      checkOutput("flush 20 busy", busy, 1);
      applyStimulus("flush20", 0);
      checkOutput("flush done busy", busy, 0);
      checkOutput("flush underrun", underrun_cnt, 0);

      // Symbol 0 survived FLUSH and IDLE
      start = 1'b1;
      tick(1);
      start = 1'b0;
      applyStimulus("retained", -131072);

      // start in RUN at phase 1 must not clear the phase
      start = 1'b1;
      tick(1);
      start = 1'b0;

      // 3 stuffed zeros then 300 empty symbol slots, strobe every 2 clocks
      nonzero_seen = 1'b0;
      for (int i = 0; i < 1203; i++) begin
         samp_en = 1'b1;
         tick(1);
         samp_en = 1'b0;
         if (x_out !== 18'h0 || x_valid !== 1'b1) begin
            nonzero_seen = 1'b1;
         end
         if (i == 2) begin
            checkOutput("underrun before slot", underrun_cnt, 0);
         end
         if (i == 3) begin
            checkOutput("underrun first slot", underrun_cnt, 1);
         end
         tick(1);
      end
      checkOutput("underrun samples zero", nonzero_seen, 0);
      checkOutput("underrun saturated", underrun_cnt, 255);

      // Reset mid-RUN with queued symbols and busy inputs
      pushSym(2'd1);
      pushSym(2'd2);
      pushSym(2'd3);
      samp_en = 1'b1;
      tick(1);
      samp_en = 1'b0;
      checkOutput("pre-reset x_out", $signed(x_out), -43690);
      reset     = 1'b1;
      samp_en   = 1'b1;
      sym_valid = 1'b1;
      start     = 1'b1;
      tick(1);
      reset     = 1'b0;
      samp_en   = 1'b0;
      sym_valid = 1'b0;
      start     = 1'b0;
      checkOutput("midrst x_out", $signed(x_out), 0);
      checkOutput("midrst x_valid", x_valid, 0);
      checkOutput("midrst busy", busy, 0);
      checkOutput("midrst underrun", underrun_cnt, 0);
      checkOutput("midrst sym_ready", sym_ready, 1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      applyStimulus("midrst empty", 0);
      checkOutput("midrst fifo empty", underrun_cnt, 1);

      // Simultaneous start and stop in IDLE: RUN, stop discarded
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      pushSym(2'd2);
      start = 1'b1;
      stop  = 1'b1;
      tick(1);
      start = 1'b0;
      stop  = 1'b0;
      applyStimulus("ss p0", 43690);
      applyStimulus("ss p1", 0);
      applyStimulus("ss p2", 0);
      applyStimulus("ss p3", 0);
      applyStimulus("ss slot2", 0);
      checkOutput("ss no flush", underrun_cnt, 1);
      checkOutput("ss busy", busy, 1);

`ifdef TX_SCHED_IMPULSE_EN
      // Impulse: one full-scale sample, then 21 zeros, back to IDLE
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      impulse_req = 1'b1;
      tick(1);
      impulse_req = 1'b0;
      applyStimulus("imp peak", 131071);
      checkOutput("imp busy", busy, 1);
      for (int i = 0; i < 20; i++) begin
         applyStimulus($sformatf("imp zero%0d", i), 0);
      end
      checkOutput("imp busy 20", busy, 1);
      applyStimulus("imp zero20", 0);
      checkOutput("imp idle", busy, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
